lut_stream_checker: RTL and testbench
=====================================

Name: lut_stream_checker

Overview:
- Parametrised, multi-channel self-checking monitor for BKM datapath blocks (LUT decoders, iteration stages).
- Aligns golden values to DUT results through a programmable-latency delay line and classifies per-channel |res-exp| against warning/error tolerances.
- Keeps saturating statistics, captures the first failure and optionally halts.
- Instantiated in bench top levels beside the DUT; not synthesised into silicon.

Parameters:
- NCH, 4, number of independent data channels compared in parallel.
- W, 64, width of each channel word.
- LAT, 3, DUT latency in cycles from golden input to result; legal range 1..64.
- WARN_TOL, 0, largest delta accepted silently; a delta above this raises a warning.
- ERR_TOL, 1, largest delta accepted as a warning; a delta above this raises an error. Must satisfy ERR_TOL >= WARN_TOL.
- CNT_W, 32, width of the statistic counters.

Ports:
- clk  in  1  bench clock.
- arst  in  1  asynchronous active-high reset.
- srst  in  1  synchronous active-high clear, same effect as arst.
- enable  in  1  advance/compare enable; when low, all state freezes.
- stop_on_err  in  1  when high, the first error moves the block to HALT.
- exp_valid  in  1  golden word present this cycle.
- exp_data  in  NCH*W  golden words, channel k at bits [k*W +: W].
- res_valid  in  1  DUT result present this cycle.
- res_data  in  NCH*W  DUT results, same packing as exp_data.
- war  out  NCH  per-channel warning, registered.
- err  out  NCH  per-channel error, registered.
- delta  out  NCH*W  per-channel absolute difference, registered.
- proto_err  out  1  alignment fault pulse: result without golden, or golden without result.
- halted  out  1  high while in HALT.
- n_checks, n_warns, n_errs  out  CNT_W each  saturating counters.
- first_err_ch  out  $clog2(NCH) max 1  channel index of the first error.
- first_err_delta  out  W  delta of the first error.
- first_err_seen  out  1  sticky flag, set on the first error.

Behaviour:
- Reset (arst asynchronous, or srst sampled at clk):
  - every output goes to 0;
  - the delay line is emptied;
  - state goes to RUN.
- Delay line:
  - LAT-stage shift register of {exp_valid, exp_data}.
  - Shifts each cycle while enable=1 and state=RUN; the stage-LAT output is the "aligned golden".
- Compare, when enable=1 and state=RUN:
  - Both res_valid and the aligned valid are high: compute delta_k = |res_k - exp_k| (unsigned, W bits, no overflow by construction).
  - Classification per channel:
    - err_k = delta_k > ERR_TOL;
    - war_k = delta_k > WARN_TOL and not err_k.
  - Exactly one of the two valids is high: proto_err=1 for one cycle; war, err and delta are 0; counters are unchanged except n_errs, which increments by 1.
  - Neither valid is high: war, err and delta are 0.
- Latency: outputs are registered 1 cycle after the res_valid sample.
- Counters, all saturating at 2^CNT_W-1 with no wrap:
  - n_checks += 1 per compared beat;
  - n_warns += popcount(war);
  - n_errs += popcount(err) + proto_err.
- First-error capture:
  - On the first beat with any err bit set, latch the lowest erring channel index and its delta, and set first_err_seen.
  - The capture holds until reset.
  - A proto_err alone sets first_err_seen with ch=0 and delta=0.
- FSM states: RUN, HALT.
  - RUN -> HALT on any error or proto_err while stop_on_err=1. The transition takes effect on the same edge that registers that error.
  - HALT -> RUN only by arst or srst.
  - In HALT: the delay line and counters freeze, war/err/delta/proto_err are 0, and halted=1.
- enable=0: nothing shifts, no compare occurs, pulse outputs go to 0, and counters hold.
- Mid-stream reset: the pipeline is discarded, and the first LAT result beats after reset are expected to produce proto_err unless golden input was also supplied LAT cycles earlier.
- Simultaneous saturation: a counter at its maximum stays at its maximum.

Optional Feature:
- Macro: LUT_CHECKER_SIGNED_EN.
- Defined: each channel word is two's complement, and delta = |sext(res) - sext(exp)| computed in W+1 bits, clamped to 2^W-1.
- Undefined: unsigned subtraction as specified above.
- Signed mode also selects $signed formatting in the optional end-of-test summary task.

Decomposition:
- Package lut_checker_pkg holds:
  - the localparam for the FSM encoding (RUN=1'b0, HALT=1'b1);
  - a function abs_diff(a,b,signed_mode);
  - a saturating add function.
- One natural sub-module: lut_checker_delay (parametrised LAT-deep valid+data shift register with an enable).

Test Plan (NCH=4, W=16, LAT=3, WARN_TOL=0, ERR_TOL=1 unless noted):
- Identical streams of 10 beats -> war=0, err=0, n_checks=10, n_warns=0, n_errs=0, no proto_err.
- Channel 2 result = exp+1 on beat 5 -> war=4'b0100, delta[2]=1, n_warns=1, err=0.
- Channel 1 result = exp+7 and channel 3 result = exp-9 on beat 4, with stop_on_err=1:
  - registered outputs: err=4'b1010, first_err_ch=1, first_err_delta=7;
  - halted=1 from the next cycle;
  - further beats are ignored and n_checks stays at 4.
- res_valid asserted 2 cycles after exp_valid (LAT mismatch) -> proto_err pulse at the golden emergence and again at the result; n_errs=2.
- CNT_W=3, 9 warning beats -> n_warns saturates at 7.
- enable low for 5 cycles mid-stream with the inputs held -> delay line frozen, alignment preserved, no proto_err. Then arst mid-stream -> all outputs are 0 immediately (asynchronous), and state is RUN.

Source files
------------

// File: rtl/lut_checker_pkg.sv
// Shared types and helpers for the lut_stream_checker bench monitor.
// Optional feature macro: LUT_CHECKER_SIGNED_EN (two's-complement channel words).
package lut_checker_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Working widths for the generic helpers; callers extend into these.
  localparam int unsigned MAXW = 128;
  localparam int unsigned MAXC = 64;

  // |a - b| on operands already extended to MAXW bits (sign- or zero-extended).
  function automatic logic [MAXW-1:0] abs_diff(input logic [MAXW-1:0] a,
                                               input logic [MAXW-1:0] b,
                                               input logic            signed_mode);
    logic a_ge_b;
    a_ge_b = signed_mode ? ($signed(a) >= $signed(b)) : (a >= b);
    return a_ge_b ? (a - b) : (b - a);
  endfunction

  // a + inc, clamped at max_v.
  function automatic logic [MAXC-1:0] sat_add(input logic [MAXC-1:0] a,
                                              input logic [MAXC-1:0] inc,
                                              input logic [MAXC-1:0] max_v);
    logic [MAXC:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return (sum > {1'b0, max_v}) ? max_v : sum[MAXC-1:0];
  endfunction

endpackage

// File: rtl/lut_checker_delay.sv
// LAT-deep shift register of {valid, data} that aligns golden words to DUT results.
module lut_checker_delay #(
  parameter int LAT = 3,
  parameter int DW  = 64
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          srst,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [DW:0] r_stage [LAT];

  // Shift one stage per enabled cycle; both resets empty the line.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else if (srst) begin
      for (int unsigned i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= {i_valid, i_data};
      for (int unsigned i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_valid = r_stage[LAT-1][DW];
  assign o_data  = r_stage[LAT-1][DW-1:0];

endmodule

// File: rtl/lut_stream_checker.sv
// Multi-channel self-checking monitor: aligns golden words through a delay line,
// classifies |res-exp| per channel, keeps saturating stats and first-error capture.
// Optional feature macro: LUT_CHECKER_SIGNED_EN (signed channel words).
module lut_stream_checker
  import lut_checker_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 64,
  parameter int LAT      = 3,
  parameter int WARN_TOL = 0,
  parameter int ERR_TOL  = 1,
  parameter int CNT_W    = 32,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               srst,
  input  logic               enable,
  input  logic               stop_on_err,
  input  logic               exp_valid,
  input  logic [NCH*W-1:0]   exp_data,
  input  logic               res_valid,
  input  logic [NCH*W-1:0]   res_data,
  output logic [NCH-1:0]     war,
  output logic [NCH-1:0]     err,
  output logic [NCH*W-1:0]   delta,
  output logic               proto_err,
  output logic               halted,
  output logic [CNT_W-1:0]   n_checks,
  output logic [CNT_W-1:0]   n_warns,
  output logic [CNT_W-1:0]   n_errs,
  output logic [CHW-1:0]     first_err_ch,
  output logic [W-1:0]       first_err_delta,
  output logic               first_err_seen
);

`ifdef LUT_CHECKER_SIGNED_EN
  localparam logic SIGNED_MODE = 1'b1;
`else
  localparam logic SIGNED_MODE = 1'b0;
`endif

  localparam logic [W-1:0]    WTOL    = W'(WARN_TOL);
  localparam logic [W-1:0]    ETOL    = W'(ERR_TOL);
  localparam logic [MAXW-1:0] WMAX    = MAXW'({W{1'b1}});
  localparam logic [MAXC-1:0] CNT_MAX = MAXC'({CNT_W{1'b1}});

  state_t              r_state;
  logic                r_halted;
  logic [NCH-1:0]      r_war, r_err;
  logic [NCH*W-1:0]    r_delta;
  logic                r_proto;
  logic [CNT_W-1:0]    r_n_checks, r_n_warns, r_n_errs;
  logic [CHW-1:0]      r_first_ch;
  logic [W-1:0]        r_first_delta;
  logic                r_first_seen;

  logic                w_al_valid;
  logic [NCH*W-1:0]    w_al_data;
  logic                w_active, w_cmp, w_proto, w_any_fail;
  logic [NCH*W-1:0]    w_delta;
  logic [NCH-1:0]      w_war, w_err;
  logic [MAXC-1:0]     w_nwar, w_nerr;
  logic [CHW-1:0]      w_first_ch;
  logic [W-1:0]        w_first_delta;
  logic                w_found;
  logic [MAXW-1:0]     w_ext_r, w_ext_e, w_diff;

  assign w_active   = enable && (r_state == RUN);
  assign w_cmp      = w_active && res_valid && w_al_valid;
  assign w_proto    = w_active && (res_valid ^ w_al_valid);
  assign w_any_fail = (w_cmp && (|w_err)) || w_proto;

  lut_checker_delay #(
    .LAT (LAT),
    .DW  (NCH*W)
  ) u_delay (
    .clk     (clk),
    .arst    (arst),
    .srst    (srst),
    .i_en    (w_active),
    .i_valid (exp_valid),
    .i_data  (exp_data),
    .o_valid (w_al_valid),
    .o_data  (w_al_data)
  );

  // Per-channel delta, classification, popcounts and lowest erring channel.
  always_comb begin
    w_delta       = '0;
    w_war         = '0;
    w_err         = '0;
    w_nwar        = '0;
    w_nerr        = '0;
    w_first_ch    = '0;
    w_first_delta = '0;
    w_found       = 1'b0;
    w_ext_r       = '0;
    w_ext_e       = '0;
    w_diff        = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_ext_r = {{(MAXW-W){SIGNED_MODE & res_data[k*W+W-1]}},  res_data[k*W +: W]};
      w_ext_e = {{(MAXW-W){SIGNED_MODE & w_al_data[k*W+W-1]}}, w_al_data[k*W +: W]};
      w_diff  = abs_diff(w_ext_r, w_ext_e, SIGNED_MODE);
      if (w_cmp) begin
        w_delta[k*W +: W] = (w_diff > WMAX) ? '1 : w_diff[W-1:0];
        w_err[k] = w_delta[k*W +: W] > ETOL;
        w_war[k] = (w_delta[k*W +: W] > WTOL) && !w_err[k];
      end
      w_nwar = w_nwar + MAXC'(w_war[k]);
      w_nerr = w_nerr + MAXC'(w_err[k]);
      if (w_err[k] && !w_found) begin
        w_found       = 1'b1;
        w_first_ch    = CHW'(k);
        w_first_delta = w_delta[k*W +: W];
      end
    end
    w_nerr = w_nerr + MAXC'(w_proto);
  end

  // RUN/HALT control, registered compare results, statistics and first-error capture.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= RUN;
      r_halted      <= 1'b0;
      r_war         <= '0;
      r_err         <= '0;
      r_delta       <= '0;
      r_proto       <= 1'b0;
      r_n_checks    <= '0;
      r_n_warns     <= '0;
      r_n_errs      <= '0;
      r_first_ch    <= '0;
      r_first_delta <= '0;
      r_first_seen  <= 1'b0;
    end else if (srst) begin
      r_state       <= RUN;
      r_halted      <= 1'b0;
      r_war         <= '0;
      r_err         <= '0;
      r_delta       <= '0;
      r_proto       <= 1'b0;
      r_n_checks    <= '0;
      r_n_warns     <= '0;
      r_n_errs      <= '0;
      r_first_ch    <= '0;
      r_first_delta <= '0;
      r_first_seen  <= 1'b0;
    end else begin
      r_war   <= w_war;
      r_err   <= w_err;
      r_delta <= w_delta;
      r_proto <= w_proto;
      if (w_cmp) begin
        r_n_checks <= CNT_W'(sat_add(MAXC'(r_n_checks), MAXC'(1), CNT_MAX));
        r_n_warns  <= CNT_W'(sat_add(MAXC'(r_n_warns), w_nwar, CNT_MAX));
      end
      if (w_cmp || w_proto) begin
        r_n_errs <= CNT_W'(sat_add(MAXC'(r_n_errs), w_nerr, CNT_MAX));
      end
      if (w_any_fail && !r_first_seen) begin
        r_first_seen  <= 1'b1;
        r_first_ch    <= w_first_ch;
        r_first_delta <= w_first_delta;
      end
      if (w_any_fail && stop_on_err) begin
        r_state  <= HALT;
        r_halted <= 1'b1;
      end
    end
  end

  assign war             = r_war;
  assign err             = r_err;
  assign delta           = r_delta;
  assign proto_err       = r_proto;
  assign halted          = r_halted;
  assign n_checks        = r_n_checks;
  assign n_warns         = r_n_warns;
  assign n_errs          = r_n_errs;
  assign first_err_ch    = r_first_ch;
  assign first_err_delta = r_first_delta;
  assign first_err_seen  = r_first_seen;

endmodule

// File: tb/tb_lut_stream_checker.sv
// Self-checking bench for lut_stream_checker: directed scenarios plus random
// stimulus, compared every cycle against a queue-based behavioural model.
module tb_lut_stream_checker;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int LAT = 3;
  localparam int WARN_TOL = 0;
  localparam int ERR_TOL  = 1;

  logic clk = 1'b0;
  logic arst, srst, enable, stop_on_err;
  logic exp_valid, res_valid;
  logic [63:0] exp_data, res_data;

  logic [3:0]  war, err, s_war, s_err;
  logic [63:0] delta, s_delta;
  logic        proto_err, halted, first_err_seen, s_proto_err, s_halted, s_first_err_seen;
  logic [31:0] n_checks, n_warns, n_errs;
  logic [2:0]  s_n_checks, s_n_warns, s_n_errs;
  logic [1:0]  first_err_ch, s_first_err_ch;
  logic [15:0] first_err_delta, s_first_err_delta;

  int n_errors = 0;
  int n_total  = 0;

  // Behavioural model state
  logic [64:0]     mq[$];
  bit              m_run;
  logic [3:0]      m_war, m_err;
  logic [63:0]     m_delta;
  bit              m_proto, m_fseen;
  logic [1:0]      m_fch;
  logic [15:0]     m_fdelta;
  longint unsigned m_chk, m_wrn, m_ers;

  always #5 clk = ~clk;

  lut_stream_checker #(.NCH(NCH), .W(W), .LAT(LAT), .WARN_TOL(WARN_TOL),
                       .ERR_TOL(ERR_TOL), .CNT_W(32)) u_dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .stop_on_err(stop_on_err),
    .exp_valid(exp_valid), .exp_data(exp_data), .res_valid(res_valid), .res_data(res_data),
    .war(war), .err(err), .delta(delta), .proto_err(proto_err), .halted(halted),
    .n_checks(n_checks), .n_warns(n_warns), .n_errs(n_errs),
    .first_err_ch(first_err_ch), .first_err_delta(first_err_delta),
    .first_err_seen(first_err_seen));

  lut_stream_checker #(.NCH(NCH), .W(W), .LAT(LAT), .WARN_TOL(WARN_TOL),
                       .ERR_TOL(ERR_TOL), .CNT_W(3)) u_dut_small (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .stop_on_err(stop_on_err),
    .exp_valid(exp_valid), .exp_data(exp_data), .res_valid(res_valid), .res_data(res_data),
    .war(s_war), .err(s_err), .delta(s_delta), .proto_err(s_proto_err), .halted(s_halted),
    .n_checks(s_n_checks), .n_warns(s_n_warns), .n_errs(s_n_errs),
    .first_err_ch(s_first_err_ch), .first_err_delta(s_first_err_delta),
    .first_err_seen(s_first_err_seen));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] satc(input longint unsigned v, input int bits);
    longint unsigned mx;
    mx = (64'(1) << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int absdiff(input logic [15:0] a, input logic [15:0] b);
    int ai, bi;
`ifdef LUT_CHECKER_SIGNED_EN
    ai = int'($signed(a));
    bi = int'($signed(b));
`else
    ai = int'(a);
    bi = int'(b);
`endif
    return (ai >= bi) ? ai - bi : bi - ai;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back('0);
    m_run = 1; m_war = '0; m_err = '0; m_delta = '0; m_proto = 0;
    m_fseen = 0; m_fch = '0; m_fdelta = '0;
    m_chk = 0; m_wrn = 0; m_ers = 0;
  endtask

  // Predict the state after the coming clock edge from the inputs now applied.
  task automatic model_clock();
    logic [64:0] g;
    int d;
    if (srst) begin
      model_reset();
      return;
    end
    m_war = '0; m_err = '0; m_delta = '0; m_proto = 0;
    if (enable && m_run) begin
      g = mq.pop_front();
      mq.push_back({exp_valid, exp_data});
      if (g[64] && res_valid) begin
        m_chk++;
        for (int c = 0; c < NCH; c++) begin
          d = absdiff(res_data[c*16 +: 16], g[c*16 +: 16]);
          m_delta[c*16 +: 16] = 16'(d);
          if (d > ERR_TOL) begin
            m_err[c] = 1'b1; m_ers++;
          end else if (d > WARN_TOL) begin
            m_war[c] = 1'b1; m_wrn++;
          end
        end
      end else if (g[64] != res_valid) begin
        m_proto = 1; m_ers++;
      end
      if (m_err != 0 || m_proto) begin
        if (!m_fseen) begin
          m_fseen = 1; m_fch = '0;
          for (int c = NCH-1; c >= 0; c--) if (m_err[c]) m_fch = 2'(c);
          m_fdelta = m_delta[m_fch*16 +: 16];
        end
        if (stop_on_err) m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("war", 64'(war), 64'(m_war));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("delta", delta, m_delta);
    check_eq("proto_err", 64'(proto_err), 64'(m_proto));
    check_eq("halted", 64'(halted), 64'(!m_run));
    check_eq("n_checks", 64'(n_checks), satc(m_chk, 32));
    check_eq("n_warns", 64'(n_warns), satc(m_wrn, 32));
    check_eq("n_errs", 64'(n_errs), satc(m_ers, 32));
    check_eq("first_seen", 64'(first_err_seen), 64'(m_fseen));
    check_eq("first_ch", 64'(first_err_ch), 64'(m_fch));
    check_eq("first_delta", 64'(first_err_delta), 64'(m_fdelta));
    check_eq("s_war", 64'(s_war), 64'(m_war));
    check_eq("s_err", 64'(s_err), 64'(m_err));
    check_eq("s_delta", s_delta, m_delta);
    check_eq("s_proto_err", 64'(s_proto_err), 64'(m_proto));
    check_eq("s_halted", 64'(s_halted), 64'(!m_run));
    check_eq("s_n_checks", 64'(s_n_checks), satc(m_chk, 3));
    check_eq("s_n_warns", 64'(s_n_warns), satc(m_wrn, 3));
    check_eq("s_n_errs", 64'(s_n_errs), satc(m_ers, 3));
    check_eq("s_first_seen", 64'(s_first_err_seen), 64'(m_fseen));
    check_eq("s_first_ch", 64'(s_first_err_ch), 64'(m_fch));
    check_eq("s_first_delta", 64'(s_first_err_delta), 64'(m_fdelta));
  endtask

  task automatic cyc(input logic ev, input logic [63:0] ed, input logic rv, input logic [63:0] rd);
    exp_valid = ev; exp_data = ed; res_valid = rv; res_data = rd;
    model_clock();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_srst();
    srst = 1'b1;
    cyc(1'b0, '0, 1'b0, '0);
    srst = 1'b0;
  endtask

  // n golden beats, results rlat cycles later; pert added on beat pbeat (-2: every beat);
  // an enable-low gap of 5 cycles with inputs held is inserted before cycle gap_at.
  task automatic stream(input int n, input int rlat, input int pbeat,
                        input logic [63:0] pert, input int gap_at);
    logic [63:0] ga [64];
    logic        ev, rv;
    logic [63:0] ed, rd;
    int j;
    for (int i = 0; i < n + rlat; i++) begin
      ev = (i < n);
      ed = '0;
      if (ev) begin
        for (int c = 0; c < NCH; c++) ed[c*16 +: 16] = 16'(16 + $urandom_range(0, 16'h3000));
        ga[i] = ed;
      end
      j  = i - rlat;
      rv = (j >= 0) && (j < n);
      rd = '0;
      if (rv) begin
        for (int c = 0; c < NCH; c++)
          rd[c*16 +: 16] = ga[j][c*16 +: 16] +
                           ((pbeat == -2 || pbeat == j) ? pert[c*16 +: 16] : 16'h0);
      end
      if (i == gap_at) begin
        enable = 1'b0;
        for (int g = 0; g < 5; g++) cyc(ev, ed, rv, rd);
        enable = 1'b1;
      end
      cyc(ev, ed, rv, rd);
    end
  endtask

  initial begin
    logic [64:0] al;
    logic [63:0] ed, rd;
    logic        ev, rv;
    int          p;

    arst = 1'b1; srst = 1'b0; enable = 1'b0; stop_on_err = 1'b0;
    exp_valid = 1'b0; exp_data = '0; res_valid = 1'b0; res_data = '0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();
    compare_all();
    enable = 1'b1;

    // Identical streams
    stream(10, LAT, -1, '0, -1);
    check_eq("t1_n_checks", 64'(n_checks), 64'd10);
    check_eq("t1_n_errs", 64'(n_errs), 64'd0);

    // Channel 2 off by one on beat 5
    do_srst();
    stream(10, LAT, 5, 64'h0000_0001_0000_0000, -1);
    check_eq("t2_n_warns", 64'(n_warns), 64'd1);
    check_eq("t2_n_errs", 64'(n_errs), 64'd0);

    // Errors on ch1 (+7) and ch3 (-9) on the 4th beat, halting
    do_srst();
    stop_on_err = 1'b1;
    stream(8, LAT, 3, 64'hFFF7_0000_0007_0000, -1);
    check_eq("t3_halted", 64'(halted), 64'd1);
    check_eq("t3_n_checks", 64'(n_checks), 64'd4);
    check_eq("t3_first_ch", 64'(first_err_ch), 64'd1);
    check_eq("t3_first_delta", 64'(first_err_delta), 64'd7);
    check_eq("t3_n_errs", 64'(n_errs), 64'd2);
    stop_on_err = 1'b0;

    // Result arrives 2 cycles late
    do_srst();
    stream(1, LAT + 2, -1, '0, -1);
    check_eq("t4_n_errs", 64'(n_errs), 64'd2);
    check_eq("t4_n_checks", 64'(n_checks), 64'd0);

    // Counter saturation on the 3-bit instance
    do_srst();
    stream(9, LAT, -2, 64'h0000_0000_0000_0001, -1);
    check_eq("t5_s_n_warns", 64'(s_n_warns), 64'd7);
    check_eq("t5_n_warns", 64'(n_warns), 64'd9);

    // Enable gap mid-stream, then asynchronous reset mid-stream
    do_srst();
    stream(12, LAT, 7, 64'h0000_0000_0005_0000, 6);
    check_eq("t6_n_checks", 64'(n_checks), 64'd12);
    check_eq("t6_proto_free", 64'(n_errs), 64'd1);
    exp_valid = 1'b1; res_valid = 1'b1;
    #2;
    arst = 1'b1;
    #1;
    check_eq("t6_arst_n_checks", 64'(n_checks), 64'd0);
    check_eq("t6_arst_n_errs", 64'(n_errs), 64'd0);
    check_eq("t6_arst_seen", 64'(first_err_seen), 64'd0);
    check_eq("t6_arst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    compare_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      stop_on_err = ($urandom_range(0, 7) == 0);
      srst        = ($urandom_range(0, 29) == 0) || (!m_run && $urandom_range(0, 3) == 0);
      al = mq[0];
      ev = ($urandom_range(0, 3) != 0);
      ed = {$urandom, $urandom};
      rv = al[64] ^ ($urandom_range(0, 99) < 3);
      rd = '0;
      for (int c = 0; c < NCH; c++) begin
        p = int'($urandom_range(0, 9));
        case (p)
          7:       rd[c*16 +: 16] = al[c*16 +: 16] + 16'd1;
          8:       rd[c*16 +: 16] = al[c*16 +: 16] - 16'd1;
          9:       rd[c*16 +: 16] = 16'($urandom);
          default: rd[c*16 +: 16] = al[c*16 +: 16];
        endcase
      end
      cyc(ev, ed, rv, rd);
      srst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_total);
    $finish;
  end

endmodule
